crossbar_ctl_sequencer: RTL and testbench

Upstream control stage for the 4x4 4-bit crossbar. It drives the crossbar's 5-bit control word.
- Holds a small program of control words, written by a host.
- On start, steps through the programmed words, holding each one for a programmable number of cycles.
- Supports one-shot and looping playback.
- Its `control`/`ctl_valid` outputs connect directly to the crossbar `control` input and its lane-capture logic.

---
 rtl/crossbar_pkg.sv | 12 +
 rtl/ctl_prog_mem.sv | 27 ++
 rtl/crossbar_ctl_sequencer.sv | 152 +++++++++++++++
 tb/tb_crossbar_ctl_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// Shared crossbar definitions: control-word geometry, sequencer program depth and FSM states.
// Used by the crossbar datapath, its control sequencer and their benches.
package crossbar_pkg;
  localparam int CTL_W  = 5;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int HOLD_W = 4;

  typedef logic [CTL_W-1:0] ctl_word_t;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/ctl_prog_mem.sv
// DEPTH x CTL_W program register file: async clear, synchronous write, combinational read.
// Read data is available in the same cycle; no backpressure, a write always lands when we=1.
module ctl_prog_mem
  import crossbar_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  ctl_word_t     wdata,
  input  logic [AW-1:0] raddr,
  output ctl_word_t     rdata
);

  ctl_word_t mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/crossbar_ctl_sequencer.sv
// Plays a host-written program of crossbar control words, each held hold+1 cycles, one-shot or looping.
// First word appears 1 cycle after start; no backpressure, writes during playback are rejected with wr_err.
module crossbar_ctl_sequencer
  import crossbar_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  ctl_word_t         wr_data,
  input  logic [AW:0]       len,
  input  logic [HOLD_W-1:0] hold,
  input  logic              loop,
  input  logic              start,
  input  logic              abort,
  output ctl_word_t         control,
  output logic              ctl_valid,
  output logic [AW-1:0]     step_idx,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);

  state_t            state, state_nxt;
  logic [AW:0]       len_l;
  logic [HOLD_W-1:0] hold_l, cnt, cnt_nxt;
  logic              loop_l, latch;
  logic [AW-1:0]     idx_nxt, rd_addr;
  ctl_word_t         ctl_nxt, rd_data, rd_word;
  logic              vld_nxt, done_nxt, wr_err_nxt;
  logic              mem_we, start_ok, step_end, last_step;

  assign mem_we    = wr_en && (state == IDLE);
  assign start_ok  = start && !abort && (len != '0) && (len <= (AW+1)'(DEPTH));
  assign step_end  = (cnt == hold_l);
  assign last_step = ({1'b0, step_idx} == (len_l - (AW+1)'(1)));
  assign busy      = (state == RUN);

  ctl_prog_mem u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // A write landing in the same IDLE cycle as start must be seen by the first step.
  assign rd_word = (mem_we && (wr_addr == rd_addr)) ? wr_data : rd_data;

  always_comb begin
    rd_addr = '0;
    if (state == RUN && step_end && !last_step) rd_addr = step_idx + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = RUN;
      RUN: begin
        if (abort)                                  state_nxt = IDLE;
        else if (step_end && last_step && !loop_l)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ctl_nxt    = control;
    vld_nxt    = ctl_valid;
    idx_nxt    = step_idx;
    cnt_nxt    = cnt;
    done_nxt   = 1'b0;
    wr_err_nxt = 1'b0;
    latch      = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          latch   = 1'b1;
          idx_nxt = '0;
          cnt_nxt = '0;
          ctl_nxt = rd_word;
          vld_nxt = 1'b1;
        end
      end
      RUN: begin
        wr_err_nxt = wr_en;
        if (abort) begin
          ctl_nxt = '0;
          vld_nxt = 1'b0;
          idx_nxt = '0;
          cnt_nxt = '0;
        end else if (step_end) begin
          cnt_nxt = '0;
          if (!last_step) begin
            idx_nxt = step_idx + AW'(1);
            ctl_nxt = rd_word;
          end else if (loop_l) begin
            idx_nxt = '0;
            ctl_nxt = rd_word;
          end else begin
            idx_nxt  = '0;
            ctl_nxt  = '0;
            vld_nxt  = 1'b0;
            done_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + HOLD_W'(1);
        end
      end
      default: begin
        ctl_nxt = '0;
        vld_nxt = 1'b0;
        idx_nxt = '0;
        cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      control   <= '0;
      ctl_valid <= 1'b0;
      step_idx  <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
      len_l     <= '0;
      hold_l    <= '0;
      loop_l    <= 1'b0;
    end else begin
      control   <= ctl_nxt;
      ctl_valid <= vld_nxt;
      step_idx  <= idx_nxt;
      cnt       <= cnt_nxt;
      done      <= done_nxt;
      wr_err    <= wr_err_nxt;
      if (latch) begin
        len_l  <= len;
        hold_l <= hold;
        loop_l <= loop;
      end
    end
  end

endmodule

// File: tb/tb_crossbar_ctl_sequencer.sv
// Directed bench for crossbar_ctl_sequencer: hand-computed control sequences checked cycle by cycle.
module tb_crossbar_ctl_sequencer;
  import crossbar_pkg::*;

  logic              clk, rst_n;
  logic              wr_en, loop, start, abort;
  logic [AW-1:0]     wr_addr;
  ctl_word_t         wr_data;
  logic [AW:0]       len;
  logic [HOLD_W-1:0] hold;
  ctl_word_t         control;
  logic              ctl_valid, busy, done, wr_err;
  logic [AW-1:0]     step_idx;

  int total = 0;
  int bad   = 0;

  ctl_word_t prog [8];

  crossbar_ctl_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .len       (len),
    .hold      (hold),
    .loop      (loop),
    .start     (start),
    .abort     (abort),
    .control   (control),
    .ctl_valid (ctl_valid),
    .step_idx  (step_idx),
    .busy      (busy),
    .done      (done),
    .wr_err    (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input ctl_word_t c, input logic v,
                         input logic b, input logic d);
    chk({tag, ".control"},   8'(control),   8'(c));
    chk({tag, ".ctl_valid"}, 8'(ctl_valid), 8'(v));
    chk({tag, ".busy"},      8'(busy),      8'(b));
    chk({tag, ".done"},      8'(done),      8'(d));
  endtask

  task automatic wr(input logic [AW-1:0] a, input ctl_word_t d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [AW:0] l, input logic [HOLD_W-1:0] h, input logic lp);
    len = l; hold = h; loop = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    len = '0; hold = '0; loop = 1'b0; start = 1'b0; abort = 1'b0;
    prog[0] = 5'h01; prog[1] = 5'h0A; prog[2] = 5'h15; prog[3] = 5'h1F;
    prog[4] = 5'h03; prog[5] = 5'h05; prog[6] = 5'h07; prog[7] = 5'h09;

    // Reset and idle
    #12;
    chk_out("reset", 5'h00, 1'b0, 1'b0, 1'b0);
    chk("reset.step_idx", 8'(step_idx), 8'd0);
    chk("reset.wr_err", 8'(wr_err), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("idle", 5'h00, 1'b0, 1'b0, 1'b0);
    end

    // One-shot, hold=0
    for (int i = 0; i < 4; i++) wr(AW'(i), prog[i]);
    go(4'd4, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_out("oneshot", prog[i], 1'b1, 1'b1, 1'b0);
      chk("oneshot.step_idx", 8'(step_idx), 8'(i));
      tick();
    end
    chk_out("oneshot.end", 5'h00, 1'b0, 1'b0, 1'b1);
    tick();
    chk("oneshot.done_pulse", 8'(done), 8'd0);

    // Hold stretch: each word for 3 cycles, done at T+13
    go(4'd4, 4'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        chk_out("hold2", prog[i], 1'b1, 1'b1, 1'b0);
        tick();
      end
    end
    chk_out("hold2.end", 5'h00, 1'b0, 1'b0, 1'b1);
    tick();

    // Loop len=2, abort at T+7
    go(4'd2, 4'd0, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      chk_out("loop", prog[(k - 1) % 2], 1'b1, 1'b1, 1'b0);
      if (k == 7) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    chk_out("abort", 5'h00, 1'b0, 1'b0, 1'b0);
    chk("abort.step_idx", 8'(step_idx), 8'd0);

    // Write protection and start ignored during RUN
    go(4'd4, 4'd3, 1'b1);
    wr_en = 1'b1; wr_addr = '0; wr_data = 5'h1F;
    tick();
    wr_en = 1'b0;
    chk("wrprot.wr_err", 8'(wr_err), 8'd1);
    tick();
    chk("wrprot.wr_err_pulse", 8'(wr_err), 8'd0);
    go(4'd1, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("restart_ignored.busy", 8'(busy), 8'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("wrprot.abort_busy", 8'(busy), 8'd0);
    go(4'd1, 4'd0, 1'b0);
    chk_out("wrprot.replay", 5'h01, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("wrprot.replay_end", 5'h00, 1'b0, 1'b0, 1'b1);

    // Boundary len and abort-blocked start
    go(4'd0, 4'd0, 1'b0);
    chk("len0.busy", 8'(busy), 8'd0);
    go(4'd9, 4'd0, 1'b0);
    chk("len9.busy", 8'(busy), 8'd0);
    abort = 1'b1;
    go(4'd1, 4'd0, 1'b0);
    abort = 1'b0;
    chk("abort_blocks_start.busy", 8'(busy), 8'd0);
    for (int i = 4; i < 8; i++) wr(AW'(i), prog[i]);
    go(4'd8, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk_out("len8", prog[i], 1'b1, 1'b1, 1'b0);
      chk("len8.step_idx", 8'(step_idx), 8'(i));
      tick();
    end
    chk_out("len8.end", 5'h00, 1'b0, 1'b0, 1'b1);

    // Write and start in the same cycle
    wr_en = 1'b1; wr_addr = '0; wr_data = 5'h12;
    go(4'd1, 4'd0, 1'b0);
    wr_en = 1'b0;
    chk_out("wr_start", 5'h12, 1'b1, 1'b1, 1'b0);
    chk("wr_start.wr_err", 8'(wr_err), 8'd0);
    tick();
    chk_out("wr_start.end", 5'h00, 1'b0, 1'b0, 1'b1);

    // Reset mid-run: immediate clear, no done, program cleared
    go(4'd2, 4'd1, 1'b1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("midreset", 5'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_out("midreset.after", 5'h00, 1'b0, 1'b0, 1'b0);
    go(4'd1, 4'd0, 1'b0);
    chk_out("cleared_mem", 5'h00, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("cleared_mem.end", 5'h00, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
